// File: rtl/motor_pkg.sv
// Shared definitions for motor1 blocks that consume the triangle carrier.
// One-hot gate-driver state encoding, default carrier width and dead-time counter width.
package motor_pkg;

  localparam int unsigned CARRIER_WIDTH  = 8;
  localparam int unsigned DEAD_CNT_WIDTH = 8;

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StDead = 4'b0010,
    StHi   = 4'b0100,
    StLo   = 4'b1000
  } drv_state_e;

  localparam int unsigned ST_HI_BIT = 2;
  localparam int unsigned ST_LO_BIT = 3;

endpackage

// File: rtl/carrier_edge_detect.sv
// Registers the triangle carrier, tracks its slope direction and pulses period_tick
// for one cycle whenever the slope turns from falling to rising (the carrier valley).
module carrier_edge_detect import motor_pkg::*; #(
  parameter int unsigned WIDTH = CARRIER_WIDTH
) (
  input  logic             cclk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] triangle,
  output logic [WIDTH-1:0] tri_q,
  output logic             period_tick
);

  logic dir_q, dir_d;
  logic tick_d;

  // Flat samples keep the previous direction so a held carrier never fakes a valley.
  always_comb begin
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (triangle != tri_q) begin
      dir_d  = (triangle > tri_q);
      tick_d = dir_d & ~dir_q;
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      tri_q       <= '0;
      dir_q       <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      tri_q       <= triangle;
      dir_q       <= dir_d;
      period_tick <= tick_d;
    end
  end

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Complementary gate driver: compares the carrier with a valley-synchronised duty value and
// inserts dead-time between high-side and low-side conduction; a sticky fault forces gates off.
module pwm_deadtime_driver import motor_pkg::*; #(
  parameter int unsigned WIDTH    = CARRIER_WIDTH,
  parameter int unsigned DEADTIME = 16
) (
  input  logic             cclk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] triangle,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_load,
  input  logic             enable,
  input  logic             fault,
  input  logic             fault_clr,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic [WIDTH-1:0] duty_active,
  output logic             period_tick,
  output logic             fault_latched
);

  localparam logic [DEAD_CNT_WIDTH-1:0] DeadLoad = DEAD_CNT_WIDTH'(DEADTIME - 1);

  logic [WIDTH-1:0]          tri_q;
  logic [WIDTH-1:0]          shadow_q, shadow_d;
  logic [WIDTH-1:0]          duty_active_q, duty_active_d;
  logic                      pending_q, pending_d;
  logic                      fault_latched_q, fault_latched_d;
  drv_state_e                state_q, state_d;
  logic [DEAD_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      want_hi;
  logic                      force_idle;

  carrier_edge_detect #(
    .WIDTH (WIDTH)
  ) u_carrier_edge_detect (
    .cclk        (cclk),
    .rstb        (rstb),
    .triangle    (triangle),
    .tri_q       (tri_q),
    .period_tick (period_tick)
  );

  // A load coincident with the valley bypasses the shadow so it takes effect this period.
  always_comb begin
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    duty_active_d = duty_active_q;
    if (duty_load && period_tick) begin
      shadow_d      = duty;
      duty_active_d = duty;
      pending_d     = 1'b0;
    end else begin
      if (period_tick && pending_q) begin
        duty_active_d = shadow_q;
        pending_d     = 1'b0;
      end
      if (duty_load) begin
        shadow_d  = duty;
        pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault) begin
      fault_latched_d = 1'b1;
    end else if (fault_clr) begin
      fault_latched_d = 1'b0;
    end
  end

  assign want_hi    = (tri_q < duty_active_q);
  assign force_idle = ~enable | fault | fault_latched_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_idle) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StDead;
          cnt_d   = DeadLoad;
        end
        StDead: begin
          if (cnt_q == '0) begin
            state_d = want_hi ? StHi : StLo;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StHi: begin
          if (!want_hi) begin
            state_d = StDead;
            cnt_d   = DeadLoad;
          end
        end
        StLo: begin
          if (want_hi) begin
            state_d = StDead;
            cnt_d   = DeadLoad;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      shadow_q        <= '0;
      pending_q       <= 1'b0;
      duty_active_q   <= '0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      duty_active_q   <= duty_active_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  // Gate drives are the state bits themselves: registered and never both high.
  assign pwm_hi        = state_q[ST_HI_BIT];
  assign pwm_lo        = state_q[ST_LO_BIT];
  assign duty_active   = duty_active_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed, table-driven bench for pwm_deadtime_driver with DEADTIME=4: one vector per clock,
// followed by a hand-written asynchronous reset sequence.
module tb_pwm_deadtime_driver;

  logic       cclk = 1'b0;
  logic       rstb;
  logic [7:0] triangle;
  logic [7:0] duty;
  logic       duty_load;
  logic       enable;
  logic       fault;
  logic       fault_clr;
  logic       pwm_hi;
  logic       pwm_lo;
  logic [7:0] duty_active;
  logic       period_tick;
  logic       fault_latched;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] tv;
    logic [7:0] duty;
    logic       ld, en, flt, clr;
    logic       hi, lo, tick;
    logic [7:0] da;
    logic       fl;
  } vec_t;

  vec_t vq[$];

  pwm_deadtime_driver #(
    .WIDTH    (8),
    .DEADTIME (4)
  ) dut (
    .cclk          (cclk),
    .rstb          (rstb),
    .triangle      (triangle),
    .duty          (duty),
    .duty_load     (duty_load),
    .enable        (enable),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .pwm_hi        (pwm_hi),
    .pwm_lo        (pwm_lo),
    .duty_active   (duty_active),
    .period_tick   (period_tick),
    .fault_latched (fault_latched)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic hi, input logic lo, input logic tk,
                            input logic [7:0] da, input logic fl);
    check("pwm_hi", idx, 32'(pwm_hi), 32'(hi));
    check("pwm_lo", idx, 32'(pwm_lo), 32'(lo));
    check("period_tick", idx, 32'(period_tick), 32'(tk));
    check("duty_active", idx, 32'(duty_active), 32'(da));
    check("fault_latched", idx, 32'(fault_latched), 32'(fl));
    check("gates_exclusive", idx, 32'(pwm_hi & pwm_lo), 32'd0);
  endtask

  task automatic add(input logic [7:0] tv, input logic [7:0] d, input logic ld, input logic en,
                     input logic flt, input logic clr, input logic hi, input logic lo,
                     input logic tk, input logic [7:0] da, input logic fl);
    vec_t v;
    v.tv = tv; v.duty = d; v.ld = ld; v.en = en; v.flt = flt; v.clr = clr;
    v.hi = hi; v.lo = lo; v.tick = tk; v.da = da; v.fl = fl;
    vq.push_back(v);
  endtask

  initial begin
    rstb      = 1'b0;
    triangle  = 8'd0;
    duty      = 8'd0;
    duty_load = 1'b0;
    enable    = 1'b0;
    fault     = 1'b0;
    fault_clr = 1'b0;

    //  tri  duty ld en flt clr | hi lo tk  da  fl
    // Startup with duty 128, rising carrier, first valley tick applies the load.
    add(  0, 128, 1, 1, 0, 0,   0, 0, 0,   0, 0);
    add( 16, 128, 0, 1, 0, 0,   0, 0, 1,   0, 0);
    add( 32, 128, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add( 48, 128, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add( 64, 128, 0, 1, 0, 0,   1, 0, 0, 128, 0);
    add( 96, 128, 0, 1, 0, 0,   1, 0, 0, 128, 0);
    add(128, 128, 0, 1, 0, 0,   1, 0, 0, 128, 0);
    add(160, 128, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add(192, 128, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add(224, 128, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add(255, 128, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    // Two loads in one period (64 then 32); 32 must win at the next valley.
    add(224,  64, 1, 1, 0, 0,   0, 1, 0, 128, 0);
    add(160,  32, 1, 1, 0, 0,   0, 1, 0, 128, 0);
    add( 96,  32, 0, 1, 0, 0,   0, 1, 0, 128, 0);
    add( 32,  32, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add(  0,  32, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add(  0,  32, 0, 1, 0, 0,   0, 0, 0, 128, 0);
    add( 16,  32, 0, 1, 0, 0,   0, 0, 1, 128, 0);
    add( 32,  32, 0, 1, 0, 0,   1, 0, 0,  32, 0);
    add( 48,  32, 0, 1, 0, 0,   0, 0, 0,  32, 0);
    add( 64,  32, 0, 1, 0, 0,   0, 0, 0,  32, 0);
    add( 64,  32, 0, 1, 0, 0,   0, 0, 0,  32, 0);
    add( 64,  32, 0, 1, 0, 0,   0, 0, 0,  32, 0);
    add( 64,  32, 0, 1, 0, 0,   0, 1, 0,  32, 0);
    // Two-cycle high demand is swallowed by the dead interval.
    add( 16,  32, 0, 1, 0, 0,   0, 1, 0,  32, 0);
    add( 16,  32, 0, 1, 0, 0,   0, 0, 0,  32, 0);
    add( 48,  32, 0, 1, 0, 0,   0, 0, 1,  32, 0);
    add( 48,  32, 0, 1, 0, 0,   0, 0, 0,  32, 0);
    add( 48,  32, 0, 1, 0, 0,   0, 0, 0,  32, 0);
    add( 48,  32, 0, 1, 0, 0,   0, 1, 0,  32, 0);
    // Duty 0 loaded on the tick cycle applies immediately; low side only.
    add(  0,  32, 0, 1, 0, 0,   0, 1, 0,  32, 0);
    add(  8,  32, 0, 1, 0, 0,   0, 0, 1,  32, 0);
    add(  8,   0, 1, 1, 0, 0,   0, 0, 0,   0, 0);
    add(  8,   0, 0, 1, 0, 0,   0, 0, 0,   0, 0);
    add(  8,   0, 0, 1, 0, 0,   0, 0, 0,   0, 0);
    add(  8,   0, 0, 1, 0, 0,   0, 1, 0,   0, 0);
    add(255,   0, 0, 1, 0, 0,   0, 1, 0,   0, 0);
    add(  0,   0, 0, 1, 0, 0,   0, 1, 0,   0, 0);
    add(  0,   0, 0, 1, 0, 0,   0, 1, 0,   0, 0);
    // Duty 255: high side except a one-cycle gap at 255, too short to reach low side.
    add(  1,   0, 0, 1, 0, 0,   0, 1, 1,   0, 0);
    add(  1, 255, 1, 1, 0, 0,   0, 1, 0, 255, 0);
    add(  1, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add(  1, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add(  1, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add(  1, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add(  1, 255, 0, 1, 0, 0,   1, 0, 0, 255, 0);
    add(255, 255, 0, 1, 0, 0,   1, 0, 0, 255, 0);
    add(254, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add(200, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add(100, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   1, 0, 0, 255, 0);
    // Fault in HI with a simultaneous clear: fault wins; later clear, full dead, resume.
    add( 50, 255, 0, 1, 1, 1,   0, 0, 0, 255, 1);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 1);
    add( 50, 255, 0, 1, 0, 1,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   1, 0, 0, 255, 0);
    // Enable drop forces idle; re-enable walks through a full dead interval.
    add( 50, 255, 0, 0, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   0, 0, 0, 255, 0);
    add( 50, 255, 0, 1, 0, 0,   1, 0, 0, 255, 0);

    // Reset state, checked before any clock edge.
    #1;
    check_outs(-1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    #7 rstb = 1'b1;

    foreach (vq[i]) begin
      triangle  = vq[i].tv;
      duty      = vq[i].duty;
      duty_load = vq[i].ld;
      enable    = vq[i].en;
      fault     = vq[i].flt;
      fault_clr = vq[i].clr;
      @(posedge cclk);
      #1;
      check_outs(i, vq[i].hi, vq[i].lo, vq[i].tick, vq[i].da, vq[i].fl);
    end

    // Leave a pending load behind while in HI, then reset between clock edges.
    duty      = 8'd10;
    duty_load = 1'b1;
    @(posedge cclk);
    #1;
    duty_load = 1'b0;
    check_outs(100, 1'b1, 1'b0, 1'b0, 8'd255, 1'b0);
    #2 rstb = 1'b0;
    #1;
    check_outs(101, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    #2 rstb = 1'b1;

    // After release: IDLE->DEAD, tick from 0->50 with nothing pending, then LO at duty 0.
    for (int k = 0; k < 5; k++) begin
      @(posedge cclk);
      #1;
      check_outs(102 + k, 1'b0, (k == 4), (k == 0), 8'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
Consumes the 8-bit triangle carrier produced by the motor1 triangle generator. It compares the carrier against a double-buffered duty value and drives a complementary high-side/low-side gate pair, inserting programmable dead-time at every transition. Duty updates are taken only at the carrier valley, so each PWM period is glitch-free. A sticky fault input forces both gates off.

Parameters:
WIDTH, 8, carrier and duty width in bits
DEADTIME, 16, cclk cycles during which both gates are low at each transition; legal range 1..255

Ports:
cclk  input  1  system clock
rstb  input  1  reset, asynchronous, active-low
triangle  input  WIDTH  carrier from the triangle generator; rises 0..max and falls back to 0; may hold a value for many cycles
duty  input  WIDTH  requested duty compare value
duty_load  input  1  one-cycle strobe; captures duty into the shadow register
enable  input  1  level; 0 forces both gates off
fault  input  1  level; any 1 sets fault_latched
fault_clr  input  1  one-cycle strobe; clears fault_latched
pwm_hi  output  1  high-side gate drive
pwm_lo  output  1  low-side gate drive
duty_active  output  WIDTH  duty value currently in use
period_tick  output  1  one-cycle pulse at each detected carrier valley
fault_latched  output  1  sticky fault flag

Behaviour:
- Reset (rstb=0, asynchronous) forces: state IDLE; pwm_hi=0, pwm_lo=0; duty_active=0; shadow=0; pending=0; fault_latched=0; period_tick=0; tri_q=0; dir=down; dead counter=0.
- Carrier stage: triangle is registered into tri_q every cycle.
  - dir updates only when triangle != tri_q (up if triangle > tri_q, otherwise down). Flat samples keep dir.
  - A down->up change of dir asserts period_tick for exactly 1 cycle (registered). The first rise after reset also produces a tick.
- Duty buffering:
  - duty_load captures duty into shadow and sets pending.
  - On period_tick with pending=1: duty_active<=shadow, pending<=0.
  - duty_load and tick in the same cycle: duty_active<=duty directly, pending<=0.
  - Repeated loads within one period: the last one wins.
- Demand: want_hi = (tri_q < duty_active).
  - duty_active=0 gives low-side only.
  - duty_active=255 gives high-side except while tri_q=255.
- FSM, one-hot, states IDLE/DEAD/HI/LO. pwm_hi is the HI state bit and pwm_lo is the LO state bit, so both outputs are registered and mutually exclusive by construction.
  - IDLE: both low. Moves to DEAD when enable=1 and fault_latched=0 and fault=0.
  - DEAD: both low for exactly DEADTIME cycles. At expiry, go to HI if want_hi else LO, using want_hi sampled at expiry. A demand pulse shorter than DEADTIME is therefore swallowed.
  - HI: want_hi=0 -> DEAD. LO: want_hi=1 -> DEAD.
  - From any state, enable=0, fault=1 or fault_latched=1 -> IDLE at the next edge. This has priority over all other transitions.
- Latency: a carrier crossing presented before edge N deasserts the active gate after edge N+1. The opposite gate asserts DEADTIME cycles later.
- Fault flag:
  - fault=1 sets fault_latched at the same edge at which state goes IDLE.
  - fault_clr clears fault_latched only when fault=0; fault wins if both are asserted.
  - Leaving IDLE after a fault always passes through a full DEAD interval.
- Reset mid-operation drops both gates asynchronously. The first period after reset uses duty_active=0 until a load plus tick occur.

Decomposition:
- Shared package motor_pkg holds the state encoding constants (IDLE/DEAD/HI/LO one-hot), the default CARRIER_WIDTH=8, and the DEADTIME counter width.
- One sub-module, carrier_edge_detect, contains tri_q, the dir register and period_tick generation. It is reusable by other motor1 consumers of the carrier.

Test Plan:
1. DEADTIME=4, duty_load=1 with duty=128, then triangle stepping 0..255..0 one step per cycle -> duty_active stays 0 until the first period_tick, then becomes 128. pwm_hi=1 while tri_q<128, with both gates low exactly 4 cycles at every edge. pwm_hi and pwm_lo are never both 1.
2. With duty_active=128, load duty=64 mid-period -> duty_active holds 128 until the next valley tick, then 64. Two loads (64, then 32) in one period -> 32 applied. Load coincident with tick -> applied in that same cycle.
3. duty=0 -> after the initial 4-cycle DEAD, pwm_lo=1 continuously. duty=255 -> pwm_hi=1 except near tri=255, where pwm_lo stays 0 because the demand gap is shorter than DEADTIME.
4. Carrier held so want_hi is 1 for 2 cycles with DEADTIME=4 -> no pwm_hi pulse; outputs return to LO after DEAD.
5. fault=1 while in HI -> pwm_hi=0 and fault_latched=1 after the next edge. fault_clr while fault=1 is ignored. After fault=0 and fault_clr -> 4-cycle DEAD, then gates resume.
6. rstb=0 while in HI with pending=1 -> pwm_hi drops immediately without waiting for a clock edge. All outputs and registers take their reset values; after release, the state starts IDLE->DEAD.
